// File: rtl/logic_inhibit_pipe.sv
// logic_inhibit_pipe: bitwise inhibit/implication unit with a 2-entry
// in-order result buffer and valid/ready handshakes on both sides.
// Optional feature macro: INHIBIT_POPCOUNT_EN adds the saturating
// ones_total counter of 1-bits delivered on completed pops.
module logic_inhibit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero
`ifdef INHIBIT_POPCOUNT_EN
  ,
  output logic [15:0]      ones_total
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_live;   // low until the first edge after reset release
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [WIDTH-1:0] w_res;
  logic             w_push;
  logic             w_pop;

  // Bitwise function selected by op.
  function automatic logic [WIDTH-1:0] f_logic(
    input logic [WIDTH-1:0] fa,
    input logic [WIDTH-1:0] fb,
    input logic [1:0]       fop
  );
    logic [WIDTH-1:0] r;
    case (fop)
      2'b00:   r = ~fa & fb;
      2'b01:   r = fa & ~fb;
      2'b10:   r = ~fa | fb;
      2'b11:   r = ~(fa ^ fb);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  assign w_res  = f_logic(a, b, op);
  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Handshake flags and result outputs decoded from registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        in_ready  = r_live;
        out_valid = 1'b0;
      end
      ST_ONE: begin
        in_ready  = r_live;
        out_valid = 1'b1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
    if (out_valid) begin
      s    = r_head;
      zero = (r_head == {WIDTH{1'b0}});
    end else begin
      s    = {WIDTH{1'b0}};
      zero = 1'b0;
    end
  end

  // Next-state logic for the occupancy FSM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) w_next = ST_ONE;
        else        w_next = ST_EMPTY;
      end
      ST_ONE: begin
        if (w_push && !w_pop)      w_next = ST_FULL;
        else if (!w_push && w_pop) w_next = ST_EMPTY;
        else                       w_next = ST_ONE;
      end
      ST_FULL: begin
        if (w_pop) w_next = ST_ONE;
        else       w_next = ST_FULL;
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  // State register plus the post-reset enable flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  // Result storage: head is presented on s, tail waits behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= {WIDTH{1'b0}};
      r_tail <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) r_head <= w_res;
        end
        ST_ONE: begin
          if (w_push && w_pop)  r_head <= w_res;
          else if (w_push)      r_tail <= w_res;
        end
        ST_FULL: begin
          if (w_pop) r_head <= r_tail;
        end
        default: begin
          r_head <= r_head;
        end
      endcase
    end
  end

`ifdef INHIBIT_POPCOUNT_EN
  logic [15:0] r_ones;
  logic [16:0] w_sum;

  // Number of set bits in a result word.
  function automatic logic [5:0] f_popcount(input logic [WIDTH-1:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  assign w_sum      = {1'b0, r_ones} + {11'd0, f_popcount(r_head)};
  assign ones_total = r_ones;

  // Saturating accumulation of 1-bits on each completed pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones <= 16'h0000;
    end else if (w_pop) begin
      if (w_sum[16]) r_ones <= 16'hFFFF;
      else           r_ones <= w_sum[15:0];
    end else begin
      r_ones <= r_ones;
    end
  end
`endif

endmodule
